seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Parametrised multiplexed 7-segment display controller for N_DIGITS digits.
//  Converts a loaded unsigned binary value to BCD with a sequential shift-add-3
//  engine, then time-multiplexes the digits onto shared active-low cathodes.
//  Adds leading-zero blanking, overflow indication and a busy flag.
//  Sits between the score/game logic and the board display pins.
// PARAMETERS
//  N_DIGITS  4       number of digits / anodes (2..8)
//  VAL_W     14      width of binary input value (1..32)
//  CLK_DIV   100000  clk cycles each digit stays lit (>=2)
// PORTS
//  clk       in   1         system clock, rising edge
//  reset     in   1         synchronous, active-high reset
//  value     in   VAL_W     unsigned binary value to display
//  load      in   1         1-cycle strobe: capture value, start conversion
//  blank_lz  in   1         1 = blank leading zeros
//  seg       out  7         cathodes, active low; seg[0]=CA .. seg[6]=CG
//  an        out  N_DIGITS  anodes, active low; an[0] = rightmost (ones) digit
//  busy      out  1         conversion in progress
//  overflow  out  1         last committed value > 10^N_DIGITS - 1
// BEHAVIOUR
//  Reset (sync, any state): an=all 1s, seg=7'h7F, busy=0, overflow=0,
//   display BCD register=0, digit index=0, refresh counter=0, pending cleared.
//  Conversion FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
//   IDLE: load=1 captures value, clears scratch BCD, goes SHIFT; busy=1 from next cycle.
//   SHIFT: exactly VAL_W cycles; each cycle add 3 to every scratch nibble >=5,
//    then shift left one bit pulling in the captured value MSB-first.
//   COMMIT: 1 cycle; copy scratch to display register, set overflow, busy=0
//    at the end of this cycle; return IDLE.
//   Latency: load at edge t -> display register/overflow/busy=0 updated at edge t+VAL_W+1.
//   Scratch holds enough nibbles for VAL_W bits (ceil(VAL_W*0.302)+1); only the low
//    N_DIGITS nibbles are displayed.
//  overflow = captured value > 10^N_DIGITS-1 (compared at capture, registered
//   at COMMIT). When overflow=1 every digit shows '-' (seg=7'b0111111).
//  load while busy: value stored in 1-deep pending slot (newest wins); FSM starts
//   it directly after COMMIT (no IDLE cycle). load and COMMIT in same cycle: the
//   new value is pended, never lost. Display register only changes at COMMIT.
//  Scan: refresh counter counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps to 0 and
//   digit index advances (N_DIGITS-1 wraps to 0). an and seg are registered and
//   update on that same tick: an = ~(1<<index_new), seg = pattern of digit index_new.
//   First anode (an[0]) goes low CLK_DIV cycles after reset release.
//   Exactly one an bit low after the first tick; never two.
//  Decode 0-9 standard active-low; nibble >9 (not reachable) -> seg=7'h7F.
//  Leading-zero blanking: digit k>0 blanked (seg=7'h7F, anode still strobed)
//   when blank_lz=1 and digits k..N_DIGITS-1 are all 0. Digit 0 never blanked.
//   Overflow dashes override blanking. blank_lz is sampled live at each scan tick.
//  Arithmetic: all counters wrap modulo their width; no combinational division.
// TESTING
//  Reset, idle: an=4'hF, seg=7'h7F for CLK_DIV-1 cycles, then an=4'b1110, seg=0 ('0')
//  load 1234 (N=4,VAL_W=14): busy high 14+1 cycles; scan shows 4,3,2,1 on an[0..3]
//  load 7, blank_lz=1: an[0] shows '7' (7'b1111000); an[1..3] strobed with seg=7'h7F
//  load 10000 (>9999): overflow=1, all digits '-' (7'b0111111); then load 9999 ->
//   overflow=0, four '9's
//  load 100 then load 200 two cycles later, then 300 next cycle: display ends 300,
//   200 never committed; busy continuous through both conversions
//  Assert reset mid-SHIFT: next cycle busy=0, an=all 1s, display 0; no stale COMMIT

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Bus between the score/game logic and the 7-segment scan controller:
// the value/load/blank controls going in and the display pins plus status coming back.
interface seg7_scan_ctrl_if #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned VAL_W    = 14
);
    logic [VAL_W-1:0]    value;
    logic                load;
    logic                blank_lz;
    logic [6:0]          seg;
    logic [N_DIGITS-1:0] an;
    logic                busy;
    logic                overflow;

    modport master (
        output value, load, blank_lz,
        input  seg, an, busy, overflow
    );

    modport slave (
        input  value, load, blank_lz,
        output seg, an, busy, overflow
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment controller: sequential binary-to-BCD conversion (shift-add-3)
// feeding an active-low digit scanner with leading-zero blanking and overflow dashes.
module seg7_scan_ctrl #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned VAL_W    = 14,
    parameter int unsigned CLK_DIV  = 100000
) (
    input logic             clk,
    input logic             reset,
    seg7_scan_ctrl_if.slave bus
);
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam int unsigned NIB_VAL  = (VAL_W * 302 + 999) / 1000 + 1;
    localparam int unsigned NIB      = (NIB_VAL > N_DIGITS) ? NIB_VAL : N_DIGITS;
    localparam int unsigned SCR_W    = NIB * 4;
    localparam int unsigned DISP_W   = N_DIGITS * 4;
    localparam logic [63:0] MAX_DISP = pow10(N_DIGITS) - 64'd1;
    localparam int unsigned BIT_W    = $clog2(VAL_W) + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(VAL_W - 1);
    localparam int unsigned IDX_W    = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam int unsigned REF_W    = $clog2(CLK_DIV);
    localparam logic [REF_W-1:0] LAST_REF = REF_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    state_t              state;
    logic [VAL_W-1:0]    cap;
    logic [VAL_W-1:0]    pend_val;
    logic                cap_ovf;
    logic                pend_ovf;
    logic                pend_valid;
    logic [SCR_W-1:0]    scratch;
    logic [SCR_W-1:0]    scratch_adj;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DISP_W-1:0]   disp;
    logic                overflow_r;
    logic                busy_r;
    logic                load_ovf;

    assign load_ovf = 64'(bus.value) > MAX_DISP;

    always_comb begin
        scratch_adj = scratch;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5) scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    // A load arriving in COMMIT (or one pended during SHIFT) restarts SHIFT directly,
    // so back-to-back conversions keep busy high with no IDLE gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cap        <= '0;
            pend_val   <= '0;
            cap_ovf    <= 1'b0;
            pend_ovf   <= 1'b0;
            pend_valid <= 1'b0;
            scratch    <= '0;
            bit_cnt    <= '0;
            disp       <= '0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.load) begin
                        cap     <= bus.value;
                        cap_ovf <= load_ovf;
                        scratch <= '0;
                        bit_cnt <= '0;
                        busy_r  <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scratch <= (scratch_adj << 1) | SCR_W'(cap[VAL_W-1]);
                    cap     <= cap << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) state <= S_COMMIT;
                    if (bus.load) begin
                        pend_val   <= bus.value;
                        pend_ovf   <= load_ovf;
                        pend_valid <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    disp       <= scratch[DISP_W-1:0];
                    overflow_r <= cap_ovf;
                    scratch    <= '0;
                    bit_cnt    <= '0;
                    pend_valid <= 1'b0;
                    if (bus.load) begin
                        cap     <= bus.value;
                        cap_ovf <= load_ovf;
                        state   <= S_SHIFT;
                    end else if (pend_valid) begin
                        cap     <= pend_val;
                        cap_ovf <= pend_ovf;
                        state   <= S_SHIFT;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [REF_W-1:0]    ref_cnt;
    logic [IDX_W-1:0]    idx;
    logic [N_DIGITS-1:0] an_r;
    logic [6:0]          seg_r;
    logic [N_DIGITS-1:0] zero_above;
    logic                run_zero;
    logic [3:0]          nibble;
    logic [6:0]          seg_dec;
    logic [6:0]          seg_nxt;

    always_comb begin
        zero_above = '0;
        run_zero   = 1'b1;
        for (int unsigned j = N_DIGITS; j > 0; j--) begin
            run_zero        = run_zero && (disp[(j-1)*4 +: 4] == 4'd0);
            zero_above[j-1] = run_zero;
        end

        nibble = disp[{idx, 2'b00} +: 4];
        case (nibble)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h7F;
        endcase

        if (overflow_r)                                       seg_nxt = 7'b0111111;
        else if (bus.blank_lz && idx != '0 && zero_above[idx]) seg_nxt = 7'h7F;
        else                                                  seg_nxt = seg_dec;
    end

    // idx names the digit lit on the coming tick, so the first tick after reset strobes an[0].
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt <= '0;
            idx     <= '0;
            an_r    <= '1;
            seg_r   <= 7'h7F;
        end else if (ref_cnt == LAST_REF) begin
            ref_cnt <= '0;
            idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            an_r    <= ~(N_DIGITS'(1) << idx);
            seg_r   <= seg_nxt;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    assign bus.an       = an_r;
    assign bus.seg      = seg_r;
    assign bus.busy     = busy_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (N_DIGITS=4, VAL_W=14, CLK_DIV=4): vector table
// of values with expected digit patterns, plus pending-load and reset corner sequences.
module tb_seg7_scan_ctrl;
    localparam int unsigned N  = 4;
    localparam int unsigned VW = 14;
    localparam int unsigned CD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.N_DIGITS(N), .VAL_W(VW)) bus ();

    seg7_scan_ctrl #(.N_DIGITS(N), .VAL_W(VW), .CLK_DIV(CD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [VW-1:0] value;
        logic          blz;
        logic [27:0]   segs;   // {digit3, digit2, digit1, digit0}
        logic          ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load_value(input logic [VW-1:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
    endtask

    // counts busy samples from the current one until busy drops (bounded)
    task automatic count_busy(inout int cnt);
        int guard;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 200) begin
            tick();
            guard++;
            if (bus.busy === 1'b1) cnt++;
        end
    endtask

    task automatic grab_frame(output logic [27:0] got, output int bad);
        logic [3:0] one;
        one = 4'b0001;
        got = 'x;
        bad = 0;
        repeat (N * CD) tick();
        for (int c = 0; c < int'(N * CD); c++) begin
            tick();
            if ($countones(~bus.an) != 1) bad++;
            for (int d = 0; d < int'(N); d++)
                if (bus.an == ~(one << d)) got[d*7 +: 7] = bus.seg;
        end
    endtask

    task automatic check_frame(input string name, input logic [27:0] exp);
        logic [27:0] got;
        int bad;
        grab_frame(got, bad);
        check({name, " anode one-hot"}, bad, 0);
        for (int d = 0; d < int'(N); d++)
            check($sformatf("%s digit%0d", name, d), {25'd0, got[d*7 +: 7]}, {25'd0, exp[d*7 +: 7]});
    endtask

    initial begin
        int cnt;

        vecs[0]  = '{14'd1234,  1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
        vecs[1]  = '{14'd7,     1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0};
        vecs[2]  = '{14'd10000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
        vecs[3]  = '{14'd9999,  1'b0, {7'h10, 7'h10, 7'h10, 7'h10}, 1'b0};
        vecs[4]  = '{14'd0,     1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
        vecs[5]  = '{14'd0,     1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
        vecs[6]  = '{14'd305,   1'b1, {7'h7F, 7'h30, 7'h40, 7'h12}, 1'b0};
        vecs[7]  = '{14'd1000,  1'b1, {7'h79, 7'h40, 7'h40, 7'h40}, 1'b0};
        vecs[8]  = '{14'd8642,  1'b1, {7'h00, 7'h02, 7'h19, 7'h24}, 1'b0};
        vecs[9]  = '{14'd10000, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
        vecs[10] = '{14'd16383, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};

        bus.value    = '0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset an", {28'd0, bus.an}, 32'hF);
        check("reset seg", {25'd0, bus.seg}, 32'h7F);
        check("reset busy", {31'd0, bus.busy}, 0);
        check("reset overflow", {31'd0, bus.overflow}, 0);
        reset = 1'b0;

        for (int i = 0; i < int'(CD) - 1; i++) begin
            tick();
            check($sformatf("pre-scan an %0d", i), {28'd0, bus.an}, 32'hF);
            check($sformatf("pre-scan seg %0d", i), {25'd0, bus.seg}, 32'h7F);
        end
        tick();
        check("first scan an", {28'd0, bus.an}, 32'hE);
        check("first scan seg", {25'd0, bus.seg}, 32'h40);

        foreach (vecs[i]) begin
            bus.blank_lz = vecs[i].blz;
            load_value(vecs[i].value);
            cnt = (bus.busy === 1'b1) ? 1 : 0;
            count_busy(cnt);
            check($sformatf("vec%0d busy cycles", i), cnt, VW + 1);
            check($sformatf("vec%0d overflow", i), {31'd0, bus.overflow}, {31'd0, vecs[i].ovf});
            check_frame($sformatf("vec%0d", i), vecs[i].segs);
        end

        // newest pending load wins; 200 is overwritten before it can start
        bus.blank_lz = 1'b0;
        load_value(14'd100);
        cnt = (bus.busy === 1'b1) ? 1 : 0;
        tick();
        if (bus.busy === 1'b1) cnt++;
        load_value(14'd200);
        if (bus.busy === 1'b1) cnt++;
        load_value(14'd300);
        if (bus.busy === 1'b1) cnt++;
        count_busy(cnt);
        check("pending busy cycles", cnt, 2 * (VW + 1));
        check_frame("pending 300", {7'h40, 7'h30, 7'h40, 7'h40});

        // load landing exactly on the COMMIT edge
        load_value(14'd1234);
        cnt = (bus.busy === 1'b1) ? 1 : 0;
        repeat (VW) begin
            tick();
            if (bus.busy === 1'b1) cnt++;
        end
        load_value(14'd56);
        if (bus.busy === 1'b1) cnt++;
        count_busy(cnt);
        check("commit-load busy cycles", cnt, 2 * (VW + 1));
        check_frame("commit-load 56", {7'h40, 7'h40, 7'h12, 7'h02});

        // put a visible overflow on the display, then reset mid-SHIFT
        load_value(14'd12000);
        cnt = 1;
        count_busy(cnt);
        check("pre-reset overflow", {31'd0, bus.overflow}, 1);
        load_value(14'd4321);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("mid-shift reset busy", {31'd0, bus.busy}, 0);
        check("mid-shift reset an", {28'd0, bus.an}, 32'hF);
        check("mid-shift reset seg", {25'd0, bus.seg}, 32'h7F);
        check("mid-shift reset overflow", {31'd0, bus.overflow}, 0);
        reset = 1'b0;
        cnt = 0;
        repeat (2 * (VW + 1)) begin
            tick();
            if (bus.busy !== 1'b0) cnt++;
        end
        check("no stale commit busy", cnt, 0);
        check("no stale commit overflow", {31'd0, bus.overflow}, 0);
        check_frame("after reset", {7'h40, 7'h40, 7'h40, 7'h40});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
